stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control stage directly upstream of the stopwatch time counter. It synchronizes and debounces the start/stop and lap/load push-buttons and runs the stopwatch state machine. It generates the counter control strobes: count enable tick, counter clear, load and direction, plus the preset value presented on the counter's load bus. It supports stopwatch mode (count up from zero) and timer mode (count down from a preset).

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced button changes state (>=2)
TICK_DIV, 10, clk cycles per count-enable tick (one hundredth of a second in the real design; >=2)
TICK_W, 20, prescaler counter width; must satisfy 2**TICK_W >= TICK_DIV

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  reset, asynchronous, active-high
strtstop  input  1  raw start/stop button, asynchronous to clk, active-high
lap_load  input  1  raw clear/reload button, asynchronous to clk, active-high
mode  input  1  0 = stopwatch (up), 1 = timer (down); sampled only in CLEAR
preset  input  20  five BCD digits {min, sec_msb, sec_lsb, tenths, hundredths}; sampled only in CLEAR
ce  output  1  one-cycle count-enable tick to the time counter
cnt_clr  output  1  synchronous clear strobe to the time counter
load  output  1  load strobe to the time counter
up  output  1  count direction, 1 = up
q  output  20  load value for the time counter
running  output  1  high while in RUN

Behaviour:
- Reset: clk and clr as above; clr is asynchronous, active-high. While clr is high: state = CLEAR, ce=0, cnt_clr=0, load=0, up=1, q=0, running=0. Synchronizers, debounced levels, debounce counters and prescaler are all 0.
- Button path, identical for each button:
  - 2-flop synchronizer s1 then s2.
  - Debounce counter increments each cycle s2 != db and clears when s2 == db.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 != db: db <= s2 and the counter clears.
  - Press pulse = db & ~db_prev. It lasts exactly one cycle per debounced rising edge.
  - Release produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES stable cycles are ignored.
  - Latency: if the button is first sampled high at edge k and held, the FSM state changes at edge k+DEBOUNCE_CYCLES+2.
- FSM states: CLEAR, PRELOAD, IDLE, RUN, STOP. Outputs are registered, so they are valid in the cycle the state is occupied.
  - CLEAR (one cycle): cnt_clr=1. Latch up <= ~mode and q <= preset. Next state is PRELOAD if mode=1, else IDLE.
  - PRELOAD (one cycle): load=1, q held. Next state IDLE.
  - IDLE: start press -> RUN. Lap press -> CLEAR.
  - RUN: running=1 and the prescaler counts. Start press -> STOP. Lap press is ignored.
  - STOP: prescaler value is held. Start press -> RUN. Lap press -> CLEAR.
  - Both presses in the same cycle: start/stop wins; the lap press is discarded.
- Prescaler:
  - Cleared on entry to RUN from IDLE; held, not cleared, on STOP -> RUN.
  - In RUN, increments each cycle and wraps from TICK_DIV-1 to 0.
  - ce=1 only in the cycle after the prescaler has reached TICK_DIV-1, i.e. exactly one pulse per TICK_DIV cycles. The first ce occurs TICK_DIV cycles after the IDLE->RUN edge.
  - ce is never high outside RUN. The last ce is suppressed if the RUN->STOP transition occurs on the same edge.
- cnt_clr and load are never high simultaneously and never coincide with ce.
- mode and preset changes outside CLEAR have no effect until the next CLEAR.
- clr asserted mid-RUN: all outputs return to reset values immediately (asynchronous). After release, the FSM passes through CLEAR (cnt_clr pulse) on the first edge.

Test Plan:
- Params DEBOUNCE_CYCLES=4, TICK_DIV=5. Release clr with mode=0 -> first edge cnt_clr=1 for one cycle, up=1, state IDLE, ce=0.
- strtstop held high from edge k -> running=1 at edge k+6. ce pulses every 5 cycles, first at edge k+11. Press again -> running=0, no further ce, prescaler holds.
- strtstop high for 3 cycles only (glitch) -> no state change, no ce. A bounce of 1-0-1 within 2 cycles followed by a steady high -> exactly one press.
- mode=1, preset=20'h12345, lap press from STOP -> cnt_clr one cycle, then load one cycle with q=20'h12345, up=0, state IDLE.
- Both buttons rising on the same cycle in STOP -> RUN, no CLEAR. Lap press in RUN -> ignored, ce continues.
- clr asserted mid-RUN between ticks -> ce, running, q drop to 0 asynchronously. On release: cnt_clr pulse, IDLE, first ce only after a new start press + 5 cycles.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control stage in front of the stopwatch time counter. Cleans up the two
// push-buttons (2-flop synchronizer + stability debounce + rising-edge pulse)
// and runs the stopwatch state machine that drives the counter strobes.
//
// Ports
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset
//   strtstop  raw start/stop button (asynchronous, active-high)
//   lap_load  raw clear/reload button (asynchronous, active-high)
//   mode      0 = stopwatch (count up), 1 = timer (count down); used in CLEAR
//   preset    five BCD digits {min, sec_msb, sec_lsb, tenths, hundredths}
//   ce        one-cycle count-enable tick, one per TICK_DIV cycles in RUN
//   cnt_clr   clear strobe to the time counter
//   load      load strobe to the time counter
//   up        count direction, 1 = up
//   q         value presented on the counter load bus
//   running   high while in RUN
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 10,
    parameter int unsigned TICK_W          = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        strtstop,
    input  logic        lap_load,
    input  logic        mode,
    input  logic [19:0] preset,
    output logic        ce,
    output logic        cnt_clr,
    output logic        load,
    output logic        up,
    output logic [19:0] q,
    output logic        running
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_IDLE    = 3'd2,
        ST_RUN     = 3'd3,
        ST_STOP    = 3'd4
    } state_t;

    // Bit 0 = start/stop, bit 1 = lap/load
    logic [1:0] btn_raw;
    logic [1:0] btn_press;

    assign btn_raw = {lap_load, strtstop};

    // -------------------------------------------------------------------------
    // Button conditioning, one identical slice per button.
    // The debounced level only follows the synchronized input after it has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing
    // cycle restarts the count, so short glitches never get through.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            s1_reg;
            logic            s2_reg;
            logic            db_reg;
            logic            db_prev_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    s1_reg      <= btn_raw[gi];
                    s2_reg      <= s1_reg;
                    db_prev_reg <= db_reg;
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            // Single-cycle pulse on the debounced rising edge only
            assign btn_press[gi] = db_reg & ~db_prev_reg;
        end
    endgenerate

    logic start_press;
    logic lap_press;

    assign start_press = btn_press[0];
    assign lap_press   = btn_press[1];

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;
    logic [TICK_W-1:0]  presc_reg;
    logic               presc_wrap;
    logic               ce_reg;
    logic               cnt_clr_reg;
    logic               load_reg;
    logic               up_reg;
    logic [19:0]        q_reg;
    logic               running_reg;

    assign presc_wrap = (presc_reg == TICK_LAST);

    // Start/stop is tested first everywhere, so a simultaneous lap press
    // is simply dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR:   state_next = mode ? ST_PRELOAD : ST_IDLE;
            ST_PRELOAD: state_next = ST_IDLE;
            ST_IDLE: begin
                if (start_press)    state_next = ST_RUN;
                else if (lap_press) state_next = ST_CLEAR;
            end
            ST_RUN: begin
                if (start_press)    state_next = ST_STOP;
            end
            ST_STOP: begin
                if (start_press)    state_next = ST_RUN;
                else if (lap_press) state_next = ST_CLEAR;
            end
            default:                state_next = ST_CLEAR;
        endcase
    end

    // The CLEAR and PRELOAD strobes come out of the edge that executes those
    // states, so after reset release the first edge both leaves CLEAR and
    // raises cnt_clr. running tracks the state being entered.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= ST_CLEAR;
            presc_reg   <= '0;
            ce_reg      <= 1'b0;
            cnt_clr_reg <= 1'b0;
            load_reg    <= 1'b0;
            up_reg      <= 1'b1;
            q_reg       <= '0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_clr_reg <= (state_reg == ST_CLEAR);
            load_reg    <= (state_reg == ST_PRELOAD);
            running_reg <= (state_next == ST_RUN);

            if (state_reg == ST_CLEAR) begin
                up_reg <= ~mode;
                q_reg  <= preset;
            end

            // A tick falling on the stop edge is swallowed
            ce_reg <= (state_reg == ST_RUN) && (state_next == ST_RUN) && presc_wrap;

            // Fresh start restarts the tick phase; resuming from STOP keeps it
            if ((state_reg == ST_IDLE) && (state_next == ST_RUN)) begin
                presc_reg <= '0;
            end else if (state_reg == ST_RUN) begin
                presc_reg <= presc_wrap ? '0 : presc_reg + TICK_W'(1);
            end
        end
    end

    assign ce      = ce_reg;
    assign cnt_clr = cnt_clr_reg;
    assign load    = load_reg;
    assign up      = up_reg;
    assign q       = q_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// A cycle-level reference model (history window debounce, event-driven
// stopwatch, cumulative RUN-cycle count for ticks) predicts every output
// after each clock edge; scenario tasks add directed timing checks.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int TD = 5;

    localparam int P_CLEAR   = 0;
    localparam int P_PRELOAD = 1;
    localparam int P_IDLE    = 2;
    localparam int P_RUN     = 3;
    localparam int P_STOP    = 4;

    // {ce, cnt_clr, load, up, q[19:0], running} while reset is held
    localparam logic [24:0] RST_VEC = 25'h0200000;

    logic        clk      = 1'b0;
    logic        clr      = 1'b1;
    logic        strtstop = 1'b0;
    logic        lap_load = 1'b0;
    logic        mode     = 1'b0;
    logic [19:0] preset   = '0;
    logic        ce;
    logic        cnt_clr;
    logic        load;
    logic        up;
    logic [19:0] q;
    logic        running;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit        hist   [0:1][0:DB+1];
    bit        db_lvl [0:1];
    bit        rose   [0:1];
    int        m_st;
    int        run_cnt;
    bit        m_ce, m_cnt_clr, m_load, m_up, m_running;
    bit [19:0] m_q;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD),
        .TICK_W         (20)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .strtstop(strtstop),
        .lap_load(lap_load),
        .mode    (mode),
        .preset  (preset),
        .ce      (ce),
        .cnt_clr (cnt_clr),
        .load    (load),
        .up      (up),
        .q       (q),
        .running (running)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] dut_vec();
        return {ce, cnt_clr, load, up, q, running};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_ce, m_cnt_clr, m_load, m_up, m_q, m_running};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i <= DB + 1; i++) hist[b][i] = 1'b0;
            db_lvl[b] = 1'b0;
            rose[b]   = 1'b0;
        end
        m_st      = P_CLEAR;
        run_cnt   = 0;
        m_ce      = 1'b0;
        m_cnt_clr = 1'b0;
        m_load    = 1'b0;
        m_up      = 1'b1;
        m_q       = '0;
        m_running = 1'b0;
    endtask

    // Predicts the outputs that follow the current rising edge.
    task automatic model_step();
        int nx;
        bit sp;
        bit lp;
        bit all_diff;
        bit raw [0:1];
        if (clr) begin
            model_reset();
            return;
        end
        sp     = rose[0];
        lp     = rose[1];
        raw[0] = strtstop;
        raw[1] = lap_load;

        nx = m_st;
        case (m_st)
            P_CLEAR:   nx = mode ? P_PRELOAD : P_IDLE;
            P_PRELOAD: nx = P_IDLE;
            P_IDLE:    if (sp) nx = P_RUN; else if (lp) nx = P_CLEAR;
            P_RUN:     if (sp) nx = P_STOP;
            P_STOP:    if (sp) nx = P_RUN; else if (lp) nx = P_CLEAR;
            default:   nx = P_CLEAR;
        endcase

        m_cnt_clr = (m_st == P_CLEAR);
        m_load    = (m_st == P_PRELOAD);
        if (m_st == P_CLEAR) begin
            m_up = !mode;
            m_q  = preset;
        end
        // run_cnt = cycles spent in RUN since the last fresh start
        if (m_st == P_IDLE && nx == P_RUN) run_cnt = 0;
        else if (m_st == P_RUN)            run_cnt++;
        m_ce      = (m_st == P_RUN) && (nx == P_RUN) && (run_cnt % TD == 0);
        m_running = (nx == P_RUN);
        m_st      = nx;

        // Debounced level flips once the last DB synchronized samples
        // (two cycles old and older) all disagree with it.
        for (int b = 0; b < 2; b++) begin
            for (int i = DB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = raw[b];
            all_diff = 1'b1;
            for (int i = 2; i <= DB + 1; i++) if (hist[b][i] == db_lvl[b]) all_diff = 1'b0;
            rose[b] = all_diff && !db_lvl[b];
            if (all_diff) db_lvl[b] = !db_lvl[b];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; strtstop = 1'b0; lap_load = 1'b0; mode = 1'b0; preset = 20'h54321;
        repeat (3) begin
            tick();
            n_vec++;
            if (dut_vec() !== RST_VEC) begin
                n_err++; $display("FAIL reset_hold got=%h exp=%h", dut_vec(), RST_VEC);
            end
        end
        clr = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL reset_model j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
            n_vec++;
            if (cnt_clr !== (j == 1) || ce !== 1'b0 || load !== 1'b0 || up !== 1'b1 || running !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release j=%0d cnt_clr=%b ce=%b load=%b up=%b running=%b exp cnt_clr=%b ce=0 load=0 up=1 running=0",
                         j, cnt_clr, ce, load, up, running, (j == 1));
            end
        end
        n_vec++;
        if (q !== 20'h54321) begin
            n_err++; $display("FAIL reset_q got=%h exp=54321", q);
        end
    endtask

    task automatic test_start_stop();
        logic exp_run;
        logic exp_ce;
        for (int j = 1; j <= 40; j++) begin
            strtstop = (j <= 8) || (j >= 21 && j <= 28);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL startstop_model j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
            // Start at edge k+6, ticks at k+11, k+16, k+21; the stop edge
            // k+26 coincides with a tick that must be swallowed.
            exp_run = (j >= 7) && (j <= 26);
            exp_ce  = (j == 12) || (j == 17) || (j == 22);
            n_vec++;
            if (running !== exp_run || ce !== exp_ce) begin
                n_err++;
                $display("FAIL startstop_timing j=%0d running=%b ce=%b exp running=%b ce=%b", j, running, ce, exp_run, exp_ce);
            end
        end
    endtask

    task automatic test_glitch();
        int rises;
        logic prev_run;
        for (int j = 1; j <= 20; j++) begin
            strtstop = (j <= 3);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec() || running !== 1'b0 || ce !== 1'b0) begin
                n_err++; $display("FAIL glitch j=%0d got=%h exp=%h running=%b exp running=0", j, dut_vec(), exp_vec(), running);
            end
        end
        rises = 0;
        prev_run = running;
        for (int j = 1; j <= 30; j++) begin
            strtstop = (j == 1) || (j >= 3 && j <= 12);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL bounce_model j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        n_vec++;
        if (rises !== 1 || running !== 1'b1) begin
            n_err++; $display("FAIL bounce_presses rises=%0d running=%b exp rises=1 running=1", rises, running);
        end
    endtask

    task automatic test_timer_load();
        for (int j = 1; j <= 20; j++) begin
            strtstop = (j <= 8);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL timer_stop j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (running !== 1'b0) begin
            n_err++; $display("FAIL timer_in_stop running=%b exp=0", running);
        end
        mode = 1'b1;
        preset = 20'h12345;
        for (int j = 1; j <= 20; j++) begin
            lap_load = (j <= 8);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL timer_model j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
            n_vec++;
            if (cnt_clr !== (j == 8) || load !== (j == 9) || running !== 1'b0) begin
                n_err++;
                $display("FAIL timer_strobes j=%0d cnt_clr=%b load=%b running=%b exp cnt_clr=%b load=%b running=0",
                         j, cnt_clr, load, running, (j == 8), (j == 9));
            end
            if (j >= 8) begin
                n_vec++;
                if (q !== 20'h12345 || up !== 1'b0) begin
                    n_err++; $display("FAIL timer_latch j=%0d q=%h up=%b exp q=12345 up=0", j, q, up);
                end
            end
        end
        mode = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            preset = 20'($urandom);
            tick();
            n_vec++;
            if (q !== 20'h12345 || up !== 1'b0 || dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL timer_hold j=%0d q=%h up=%b exp q=12345 up=0", j, q, up);
            end
        end
    endtask

    task automatic test_both_buttons();
        int ce_cnt;
        for (int j = 1; j <= 40; j++) begin
            strtstop = (j <= 8) || (j >= 21 && j <= 28);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL both_setup j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (running !== 1'b0) begin
            n_err++; $display("FAIL both_in_stop running=%b exp=0", running);
        end
        for (int j = 1; j <= 20; j++) begin
            strtstop = (j <= 8);
            lap_load = (j <= 8);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec() || cnt_clr !== 1'b0 || load !== 1'b0) begin
                n_err++; $display("FAIL both_same_cycle j=%0d got=%h exp=%h cnt_clr=%b exp=0", j, dut_vec(), exp_vec(), cnt_clr);
            end
        end
        n_vec++;
        if (running !== 1'b1) begin
            n_err++; $display("FAIL both_to_run running=%b exp=1", running);
        end
        ce_cnt = 0;
        for (int j = 1; j <= 30; j++) begin
            lap_load = (j <= 8);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec() || running !== 1'b1 || cnt_clr !== 1'b0) begin
                n_err++; $display("FAIL lap_in_run j=%0d got=%h exp=%h running=%b exp=1", j, dut_vec(), exp_vec(), running);
            end
            if (ce) ce_cnt++;
        end
        n_vec++;
        if (ce_cnt !== 30 / TD) begin
            n_err++; $display("FAIL lap_in_run_ticks got=%0d exp=%0d", ce_cnt, 30 / TD);
        end
    endtask

    task automatic test_async_clr();
        bit found;
        found = 1'b0;
        for (int j = 0; j < 2 * TD && !found; j++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL aclr_wait j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
            end
            if (ce === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL aclr_no_tick got=no ce within %0d cycles exp=ce", 2 * TD);
        end
        clr = 1'b1;
        #2;
        n_vec++;
        if (dut_vec() !== RST_VEC) begin
            n_err++; $display("FAIL aclr_immediate got=%h exp=%h", dut_vec(), RST_VEC);
        end
        repeat (2) tick();
        clr = 1'b0;
        preset = 20'h0A5A5;
        tick();
        n_vec++;
        if (cnt_clr !== 1'b1 || running !== 1'b0 || q !== 20'h0A5A5 || dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL aclr_release cnt_clr=%b running=%b q=%h exp cnt_clr=1 running=0 q=0a5a5", cnt_clr, running, q);
        end
        for (int j = 1; j <= 20; j++) begin
            strtstop = (j <= 8);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec() || running !== (j >= 7) || ce !== (j == 12 || j == 17)) begin
                n_err++;
                $display("FAIL aclr_restart j=%0d running=%b ce=%b exp running=%b ce=%b", j, running, ce, (j >= 7), (j == 12 || j == 17));
            end
        end
    endtask

    task automatic test_random();
        int hs;
        int hl;
        int hc;
        hs = 0; hl = 0; hc = 0;
        for (int i = 0; i < 1200; i++) begin
            if (hs == 0) begin strtstop = 1'($urandom_range(0, 1)); hs = int'($urandom_range(1, 12)); end
            hs--;
            if (hl == 0) begin lap_load = 1'($urandom_range(0, 1)); hl = int'($urandom_range(1, 12)); end
            hl--;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            preset = 20'($urandom);
            if (hc == 0 && $urandom_range(0, 299) == 0) hc = int'($urandom_range(1, 3));
            clr = (hc > 0);
            if (hc > 0) hc--;
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_stop();
        test_glitch();
        test_timer_load();
        test_both_buttons();
        test_async_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
